// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider
//  Function : Sequential unsigned restoring divider, one quotient bit per clock
//             (q = a / b, r = a % b). Requires W >= 2.
//             Optional macro SEQ_DIV_DBZ_EN adds the dbz port and a one-cycle
//             divide-by-zero shortcut.
//  Revision : 1.0  initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r
`ifdef SEQ_DIV_DBZ_EN
    ,
    output logic         dbz
`endif
);

    localparam int            C_CNT_W = $clog2(W + 1);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [W-1:0]         r_dvd;
    logic [W-1:0]         r_dvs;
    logic [W:0]           r_rem;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [W-1:0]         r_quo;
    logic [W-1:0]         r_rmd;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_zero_div;
    logic [W:0]           w_shift;
    logic [W:0]           w_diff;
    logic                 w_qbit;
    logic [W:0]           w_rem_nxt;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_BUSY) && (r_cnt == C_LAST);

`ifdef SEQ_DIV_DBZ_EN
    assign w_zero_div = w_accept && (b == '0);
`else
    assign w_zero_div = 1'b0;
`endif

    // Sign bit of the W+1 bit trial subtraction decides whether to restore.
    assign w_shift   = {r_rem[W-1:0], r_dvd[W-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[W];
    assign w_rem_nxt = w_qbit ? w_diff : w_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero_div ? S_DONE : S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rmd <= '0;
        end else if (w_accept) begin
            r_dvd <= a;
            r_dvs <= b;
            r_rem <= '0;
            r_cnt <= '0;
            if (w_zero_div) begin
                r_quo <= '1;
                r_rmd <= a;
            end
        end else if (r_state == S_BUSY) begin
            r_dvd <= {r_dvd[W-2:0], w_qbit};
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + C_CNT_W'(1);
            if (w_last) begin
                r_quo <= {r_dvd[W-2:0], w_qbit};
                r_rmd <= w_rem_nxt[W-1:0];
            end
        end
    end

`ifdef SEQ_DIV_DBZ_EN
    logic r_dbz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= w_zero_div;
        end
    end

    assign dbz = r_dbz;
`endif

    assign busy = (r_state == S_BUSY);
    assign done = (r_state == S_DONE);
    assign q    = r_quo;
    assign r    = r_rmd;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_restoring_divider
//  Function : Self-checking bench for seq_restoring_divider against an
//             arithmetic reference (a / b, a % b). Honours SEQ_DIV_DBZ_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
`ifdef SEQ_DIV_DBZ_EN
    logic         dbz;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    seq_restoring_divider #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r)
`ifdef SEQ_DIV_DBZ_EN
        ,
        .dbz   (dbz)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One division from the current (IDLE or DONE) cycle; returns the cycle of done.
    task automatic do_div(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input string tag, output int done_cyc);
        int n;
        int nbusy;
        int lat;
        int eq;
        int er;
        eq  = (tb_v == 0) ? MAXV : int'(ta) / int'(tb_v);
        er  = (tb_v == 0) ? int'(ta) : int'(ta) % int'(tb_v);
        lat = W;
`ifdef SEQ_DIV_DBZ_EN
        if (tb_v == 0) lat = 0;
`endif
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        n     = 0;
        nbusy = 0;
        while (!done && n < 3 * W) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            n++;
        end
        done_cyc = cyc;
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'(lat));
        chk({tag, " q"}, 32'(q), 32'(eq));
        chk({tag, " r"}, 32'(r), 32'(er));
        if (tb_v != 0) begin
            chk({tag, " q*b+r"}, 32'(int'(q) * int'(tb_v) + int'(r)), 32'(ta));
            chk({tag, " r<b"}, 32'(r < tb_v), 32'd1);
        end
`ifdef SEQ_DIV_DBZ_EN
        chk({tag, " dbz"}, 32'(dbz), 32'(tb_v == 0));
`endif
    endtask

    initial begin
        int c1;
        int c2;
        int n;
        int nd;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst q", 32'(q), 32'd0);
        chk("rst r", 32'(r), 32'd0);
`ifdef SEQ_DIV_DBZ_EN
        chk("rst dbz", 32'(dbz), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed cases
        do_div(4'd13, 4'd3, "d13/3", c1);
        @(posedge clk);
        #1;
        chk("done one-cycle", 32'(done), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);
        do_div(4'd15, 4'd1, "d15/1", c1);
        do_div(4'd2, 4'd9, "d2/9", c1);
        do_div(4'd9, 4'd9, "d9/9", c1);
        do_div(4'd7, 4'd0, "d7/0", c1);

        // Back-to-back: second done five cycles after the first
        do_div(4'd13, 4'd3, "b2b first", c1);
        do_div(4'd11, 4'd4, "b2b second", c2);
        chk("b2b spacing", 32'(c2 - c1), 32'(W + 1));

        // start with new operands during BUSY is ignored
        @(negedge clk);
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd3;
        @(posedge clk);
        #1;
        a = 4'd15;
        b = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 3 * W) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign latency", 32'(n), 32'(W - 2));
        chk("ign q", 32'(q), 32'd4);
        chk("ign r", 32'(r), 32'd1);

        // Asynchronous reset two cycles into BUSY
        @(negedge clk);
        start = 1'b1;
        a     = 4'd15;
        b     = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst q", 32'(q), 32'd0);
        chk("arst r", 32'(r), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        nd = 0;
        repeat (2 * W) begin
            @(posedge clk);
            #1;
            if (done || busy) nd++;
        end
        chk("arst no done", 32'(nd), 32'd0);
        do_div(4'd14, 4'd5, "post-rst", c1);

        // Random operands, b==0 included
        repeat (40) begin
            ra = W'($urandom_range(0, MAXV));
            rb = W'($urandom_range(0, MAXV));
            do_div(ra, rb, $sformatf("rnd %0d/%0d", ra, rb), c1);
        end

        // Exhaustive pairs with non-zero divisor
        for (int ia = 0; ia <= MAXV; ia++) begin
            for (int ib = 1; ib <= MAXV; ib++) begin
                do_div(W'(ia), W'(ib), $sformatf("ex %0d/%0d", ia, ib), c1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
